// File: rtl/hazard_sequencer.sv
// hazard_sequencer: ID-stage hazard and control-flow sequencer for the 5-stage MIPS core.
// Tracks pending register writes, stalls ID on RAW hazards, redirects on j and
// holds fetch on beq until EX reports the outcome (or a timeout forces not-taken).
module hazard_sequencer #(
    parameter int unsigned WB_LAT     = 3,
    parameter int unsigned BR_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifid_valid,
    input  logic [31:0] IR,
    input  logic        br_valid,
    input  logic        br_taken,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        ifid_we,
    output logic        ifid_flush,
    output logic        id_nop,
    output logic        br_err,
    output logic [15:0] stall_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_ADD   = 6'd32;
    localparam logic [5:0] FN_SUB   = 6'd34;
    localparam logic [5:0] FN_SLT   = 6'd42;

    localparam logic [1:0] SEL_SEQ  = 2'd0;
    localparam logic [1:0] SEL_BR   = 2'd1;
    localparam logic [1:0] SEL_JMP  = 2'd2;

    localparam logic [1:0] PEND_INIT = 2'(WB_LAT);
    localparam logic [7:0] TMR_LAST  = 8'(BR_TIMEOUT - 1);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        BR_WAIT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  tmr;
    logic [1:0]  pend [32];

    // instruction fields
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic        ir_unused;

    // decoded per-instruction properties
    logic        is_rtype;
    logic        is_lw;
    logic        is_sw;
    logic        is_beq;
    logic        is_j;
    logic        rd_rs_en;
    logic        rd_rt_en;
    logic        wr_en;
    logic [4:0]  dst;

    logic        haz_rs;
    logic        haz_rt;
    logic        hazard;
    logic        issue;
    logic        issue_wr;
    logic        stall_inc;

    assign op        = IR[31:26];
    assign rs        = IR[25:21];
    assign rt        = IR[20:16];
    assign rd        = IR[15:11];
    assign funct     = IR[5:0];
    assign ir_unused = ^IR[10:6];

    // Decode the IF/ID instruction into register read/write usage; unknown encodings do nothing.
    always_comb begin
        is_rtype = (op == OP_RTYPE) &&
                   ((funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_SLT));
        is_lw    = (op == OP_LW);
        is_sw    = (op == OP_SW);
        is_beq   = (op == OP_BEQ);
        is_j     = (op == OP_J);

        rd_rs_en = is_rtype | is_lw | is_sw | is_beq;
        rd_rt_en = is_rtype | is_sw | is_beq;
        wr_en    = is_rtype | is_lw;
        dst      = is_lw ? rt : rd;
    end

    // RAW hazard detection against the scoreboard; $0 is never tracked.
    always_comb begin
        haz_rs    = rd_rs_en && (rs != 5'd0) && (pend[rs] != 2'd0);
        haz_rt    = rd_rt_en && (rt != 5'd0) && (pend[rt] != 2'd0);
        hazard    = ifid_valid && (haz_rs || haz_rt);
        issue     = (state == RUN) && ifid_valid && !hazard;
        issue_wr  = issue && wr_en && (dst != 5'd0);
        stall_inc = ((state == RUN) && hazard) || (state == BR_WAIT);
    end

    // Next-state and pipeline control outputs; reset forces the bubble/hold values.
    always_comb begin
        state_nxt  = state;
        pc_we      = 1'b0;
        pc_sel     = SEL_SEQ;
        ifid_we    = 1'b0;
        ifid_flush = 1'b0;
        id_nop     = 1'b1;
        br_err     = 1'b0;

        if (rst) begin
            unique case (state)
                RUN: begin
                    br_err = br_valid;
                    if (!ifid_valid) begin
                        pc_we   = 1'b1;
                        ifid_we = 1'b1;
                    end else if (!hazard) begin
                        pc_we   = 1'b1;
                        ifid_we = 1'b1;
                        id_nop  = 1'b0;
                        if (is_j) begin
                            pc_sel     = SEL_JMP;
                            ifid_flush = 1'b1;
                        end else if (is_beq) begin
                            state_nxt = BR_WAIT;
                        end
                    end
                end
                BR_WAIT: begin
                    if (br_valid) begin
                        state_nxt = RUN;
                        if (br_taken) begin
                            pc_we      = 1'b1;
                            pc_sel     = SEL_BR;
                            ifid_flush = 1'b1;
                        end
                    end else if (tmr == TMR_LAST) begin
                        br_err    = 1'b1;
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    // State register and branch-wait timer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            tmr   <= '0;
        end else begin
            state <= state_nxt;
            if (issue && is_beq)
                tmr <= '0;
            else if (state == BR_WAIT)
                tmr <= tmr + 8'd1;
        end
    end

    // Scoreboard: age every pending entry, reload the destination on a writing issue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 32; i++)
                pend[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 32; i++) begin
                if (issue_wr && (dst == 5'(i)))
                    pend[i] <= PEND_INIT;
                else if (pend[i] != 2'd0)
                    pend[i] <= pend[i] - 2'd1;
            end
        end
    end

    // Saturating count of hazard stalls and branch-wait bubbles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if (stall_inc && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer: directed checks of stalls, branch/jump sequencing, timeout and reset.
module tb_hazard_sequencer;

    logic        clk;
    logic        rst;
    logic        ifid_valid;
    logic [31:0] IR;
    logic        br_valid;
    logic        br_taken;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        ifid_we;
    logic        ifid_flush;
    logic        id_nop;
    logic        br_err;
    logic [15:0] stall_cnt;

    int unsigned n_checks;
    int unsigned n_fail;

    // {pc_we, pc_sel, ifid_we, ifid_flush, id_nop, br_err}
    localparam logic [6:0] O_RST      = 7'b0_00_0_0_1_0;
    localparam logic [6:0] O_IDLE     = 7'b1_00_1_0_1_0;
    localparam logic [6:0] O_IDLE_ERR = 7'b1_00_1_0_1_1;
    localparam logic [6:0] O_STALL    = 7'b0_00_0_0_1_0;
    localparam logic [6:0] O_ISSUE    = 7'b1_00_1_0_0_0;
    localparam logic [6:0] O_TAKEN    = 7'b1_01_0_1_1_0;
    localparam logic [6:0] O_TMO      = 7'b0_00_0_0_1_1;

    logic [6:0] outs;
    assign outs = {pc_we, pc_sel, ifid_we, ifid_flush, id_nop, br_err};

    hazard_sequencer #(
        .WB_LAT     (3),
        .BR_TIMEOUT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ifid_valid (ifid_valid),
        .IR         (IR),
        .br_valid   (br_valid),
        .br_taken   (br_taken),
        .pc_we      (pc_we),
        .pc_sel     (pc_sel),
        .ifid_we    (ifid_we),
        .ifid_flush (ifid_flush),
        .id_nop     (id_nop),
        .br_err     (br_err),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b0;
        ifid_valid = 1'b0;
        IR         = '0;
        br_valid   = 1'b0;
        br_taken   = 1'b0;

        #2;
        check("reset_outs", 32'(outs), 32'(O_RST));
        check("reset_cnt", 32'(stall_cnt), 32'd0);
        step();
        step();
        rst = 1'b1;
        #1;
        check("idle", 32'(outs), 32'(O_IDLE));

        // 1: add $3,$1,$2 ; add $4,$3,$3 -> three stalls
        ifid_valid = 1'b1;
        IR = rtype(1, 2, 3, 32);
        #1 check("t1_add3", 32'(outs), 32'(O_ISSUE));
        step();
        IR = rtype(3, 3, 4, 32);
        for (int k = 0; k < 3; k++) begin
            #1 check("t1_stall", 32'(outs), 32'(O_STALL));
            step();
        end
        #1 check("t1_issue4", 32'(outs), 32'(O_ISSUE));
        step();
        check("t1_cnt", 32'(stall_cnt), 32'd3);

        // 2: lw $5,0($1) ; sw $5,4($2) -> three stalls; $0 never hazards
        IR = itype(35, 1, 5, 0);
        #1 check("t2_lw", 32'(outs), 32'(O_ISSUE));
        step();
        IR = itype(43, 2, 5, 4);
        for (int k = 0; k < 3; k++) begin
            #1 check("t2_sw_stall", 32'(outs), 32'(O_STALL));
            step();
        end
        #1 check("t2_sw_issue", 32'(outs), 32'(O_ISSUE));
        step();
        IR = rtype(1, 2, 0, 32);
        #1 check("t2_add0", 32'(outs), 32'(O_ISSUE));
        step();
        IR = rtype(0, 0, 6, 32);
        #1 check("t2_add6_r0", 32'(outs), 32'(O_ISSUE));
        step();
        check("t2_cnt", 32'(stall_cnt), 32'd6);

        // 3: beq taken two cycles after issue
        IR = itype(4, 1, 2, 8);
        #1 check("t3_beq", 32'(outs), 32'(O_ISSUE));
        step();
        IR = rtype(1, 1, 7, 32);
        #1 check("t3_wait", 32'(outs), 32'(O_STALL));
        step();
        br_valid = 1'b1;
        br_taken = 1'b1;
        #1 check("t3_taken", 32'(outs), 32'(O_TAKEN));
        step();
        br_valid = 1'b0;
        br_taken = 1'b0;
        #1 check("t3_run", 32'(outs), 32'(O_ISSUE));
        step();
        check("t3_cnt", 32'(stall_cnt), 32'd8);

        // 4: beq not taken -> held instr issues next cycle; then j
        IR = itype(4, 1, 2, 8);
        #1 check("t4_beq", 32'(outs), 32'(O_ISSUE));
        step();
        IR = rtype(1, 1, 8, 34);
        br_valid = 1'b1;
        #1 check("t4_nt", 32'(outs), 32'(O_STALL));
        step();
        br_valid = 1'b0;
        #1 check("t4_held", 32'(outs), 32'(O_ISSUE));
        step();
        check("t4_cnt", 32'(stall_cnt), 32'd9);
        IR = {6'd2, 26'h40};
        #1;
        check("t4_j_pcwe", 32'(pc_we), 32'd1);
        check("t4_j_sel", 32'(pc_sel), 32'd2);
        check("t4_j_flush", 32'(ifid_flush), 32'd1);
        check("t4_j_nop", 32'(id_nop), 32'd0);
        step();

        // 5: beq never resolved -> timeout on 4th wait cycle; stray br_valid in RUN
        IR = itype(4, 1, 2, 8);
        #1 check("t5_beq", 32'(outs), 32'(O_ISSUE));
        step();
        IR = rtype(1, 2, 9, 42);
        for (int k = 0; k < 3; k++) begin
            #1 check("t5_wait", 32'(outs), 32'(O_STALL));
            step();
        end
        #1 check("t5_timeout", 32'(outs), 32'(O_TMO));
        step();
        ifid_valid = 1'b0;
        br_valid   = 1'b1;
        br_taken   = 1'b1;
        #1 check("t5_stray_br", 32'(outs), 32'(O_IDLE_ERR));
        step();
        br_valid = 1'b0;
        br_taken = 1'b0;
        #1 check("t5_still_run", 32'(outs), 32'(O_IDLE));
        check("t5_cnt", 32'(stall_cnt), 32'd13);
        step();

        // 6: reset during BR_WAIT with $3 pending
        ifid_valid = 1'b1;
        IR = rtype(1, 2, 3, 32);
        #1 check("t6_add3", 32'(outs), 32'(O_ISSUE));
        step();
        IR = itype(4, 1, 2, 8);
        #1 check("t6_beq", 32'(outs), 32'(O_ISSUE));
        step();
        IR = rtype(3, 3, 9, 32);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_outs", 32'(outs), 32'(O_RST));
        check("t6_rst_cnt", 32'(stall_cnt), 32'd0);
        step();
        rst = 1'b1;
        #1 check("t6_no_stall", 32'(outs), 32'(O_ISSUE));
        step();
        check("t6_cnt_after", 32'(stall_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
